// File: rtl/nibble_packer_pkg.sv
// rtl/nibble_packer_pkg.sv - shared types and widths for the nibble packer
// NIBBLE_PACKER_PARITY_EN widens each FIFO entry by one even-parity bit.
package nibble_packer_pkg;

  localparam int NIBBLE_W = 4;
  localparam int BYTE_W   = 8;

`ifdef NIBBLE_PACKER_PARITY_EN
  localparam int ENTRY_W = BYTE_W + 1;
`else
  localparam int ENTRY_W = BYTE_W;
`endif

  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } pk_state_t;

endpackage

// File: rtl/nibble_packer_if.sv
// rtl/nibble_packer_if.sv - nibble-in / byte-out handshake bundle
// NIBBLE_PACKER_PARITY_EN adds parityo alongside datao.
interface nibble_packer_if;
  import nibble_packer_pkg::*;

  logic                validi;
  logic [NIBBLE_W-1:0] datai;
  logic                readyo;
  logic                valido;
  logic [BYTE_W-1:0]   datao;
  logic                readyi;
`ifdef NIBBLE_PACKER_PARITY_EN
  logic                parityo;

  modport master (output validi, datai, readyi,
                  input  readyo, valido, datao, parityo);
  modport slave  (input  validi, datai, readyi,
                  output readyo, valido, datao, parityo);
`else
  modport master (output validi, datai, readyi,
                  input  readyo, valido, datao);
  modport slave  (input  validi, datai, readyi,
                  output readyo, valido, datao);
`endif

endinterface

// File: rtl/nibble_packer_byte_fifo.sv
// rtl/nibble_packer_byte_fifo.sv - first-word fall-through FIFO with occupancy count
module byte_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nibble_packer.sv
// rtl/nibble_packer.sv - packs nibble pairs (low first) into bytes buffered in a FIFO
// NIBBLE_PACKER_PARITY_EN stores and presents even parity per byte on parityo.
module nibble_packer
  import nibble_packer_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  nibble_packer_if.slave   bus,
  output logic [AW:0]      count
);

  pk_state_t           state, state_d;
  logic [NIBBLE_W-1:0] hold, hold_d;
  logic                ready;
  logic                push;
  logic                full;
  logic                empty;
  logic [ENTRY_W-1:0]  wdata;
  logic [ENTRY_W-1:0]  rdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LOW;
      hold  <= '0;
    end else begin
      state <= state_d;
      hold  <= hold_d;
    end
  end

  // readyo in HIGH follows the registered full, so a pop frees space one cycle later.
  always_comb begin
    state_d = state;
    hold_d  = hold;
    ready   = 1'b0;
    push    = 1'b0;
    case (state)
      LOW: begin
        ready = 1'b1;
        if (bus.validi) begin
          hold_d  = bus.datai;
          state_d = HIGH;
        end
      end
      HIGH: begin
        ready = !full;
        if (bus.validi && !full) begin
          push    = 1'b1;
          state_d = LOW;
        end
      end
      default: begin
        state_d = LOW;
        hold_d  = '0;
      end
    endcase
  end

`ifdef NIBBLE_PACKER_PARITY_EN
  assign wdata       = {^{bus.datai, hold}, bus.datai, hold};
  assign bus.parityo = rdata[BYTE_W];
`else
  assign wdata       = {bus.datai, hold};
`endif

  assign bus.readyo = ready & rst;
  assign bus.valido = !empty;
  assign bus.datao  = rdata[BYTE_W-1:0];

  byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (!empty && bus.readyi),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (count)
  );

endmodule
